id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Issue/hazard controller on the write side of the ID/EX pipeline register: decides each cycle whether the
//  decoded instruction enters ID/EX or a bubble (Instin=16'h8040, all controls 0) is injected.
//  Owns PC/IF-ID write enables, load-use stalls, taken-branch squash and data-memory wait freeze.
//  Keeps a 1-entry history of what it issued into EX; needs no readback from ID/EX.
// PARAMETERS
//  NOP_INSTR     16'h8040  instruction word driven into ID/EX for a bubble
//  LOAD_STALL    1         bubbles inserted per load-use hazard (1..3)
//  FLUSH_CYCLES  1         bubble cycles after taken branch, first squash cycle included (1..3)
//  CNT_W         16        width of saturating statistics counters
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  id_instr     in   16  instruction in ID
//  id_window    in   2   register window of ID instruction
//  id_rs,id_rt  in   3   source register fields
//  id_use_rs    in   1   ID reads rs
//  id_use_rt    in   1   ID reads rt
//  id_dest      in   3   destination register (after RegDst select)
//  id_regwrite  in   1   ID writes a register
//  id_memread   in   1   ID is a load
//  br_taken     in   1   branch in EX resolved taken (level, valid while EX held)
//  mem_wait     in   1   data memory not ready; whole pipe must hold
//  pc_write     out  1   PC may update
//  ifid_write   out  1   IF/ID may capture
//  ifid_flush   out  1   IF/ID loads NOP_INSTR instead of fetch
//  idex_bubble  out  1   ID/EX takes NOP_INSTR and zero controls
//  idex_en      out  1   ID/EX may capture (0 only while frozen)
//  stall_cnt    out  CNT_W  load-use bubbles issued, saturating
//  flush_cnt    out  CNT_W  branch flushes taken, saturating
// BEHAVIOUR
//  Reset: state=RUN, EX-history invalid, counters 0; during rst: pc_write=ifid_write=idex_en=1,
//   ifid_flush=0, idex_bubble=1.
//  EX-history {v,memread,dest,window}: updated at every edge with idex_en=1; takes ID fields if issued,
//   cleared (v=0) if bubble.
//  Load-use hit = hist.v & hist.memread & dest!=0 & hist.window==id_window &
//   ((id_use_rs & id_rs==dest) | (id_use_rt & id_rt==dest)).
//  Outputs are combinational from state + inputs; no extra latency.
//  Priority each cycle: rst > mem_wait > br_taken > load-use hit > normal issue.
//  FSM:
//   RUN:      mem_wait -> all enables 0, save return state, go FREEZE.
//             br_taken -> ifid_flush=1, idex_bubble=1, flush_cnt++; FLUSH_CYCLES>1 ? FLUSH (cnt=FLUSH_CYCLES-1) : RUN.
//             hit      -> pc_write=ifid_write=0, idex_bubble=1, stall_cnt++; LOAD_STALL>1 ? LD_STALL (cnt=LOAD_STALL-1) : RUN.
//             else issue: all write enables 1, bubble 0.
//   LD_STALL: PC/IF-ID held, bubble issued, stall_cnt++ per cycle; cnt-- ; cnt==1 -> RUN. br_taken here overrides
//             (stall abandoned, flush taken as in RUN).
//   FLUSH:    ifid_flush=1, idex_bubble=1, pc_write=1; cnt==1 -> RUN. br_taken ignored (squashed path).
//   FREEZE:   all enables 0, history/counters hold; on mem_wait=0 resume saved state with its counter intact,
//             same cycle acts as that state.
//  Counters saturate at all-ones; no wrap. rst mid-stall/flush/freeze aborts to RUN immediately.
//  mem_wait and br_taken both high: freeze wins; flush applied after release (br_taken still held by EX).
// STRUCTURE
//  Shared pkg (pipe_pkg): NOP_INSTR constant, state encoding RUN/LD_STALL/FLUSH/FREEZE, field widths.
//  One sub-module: hazard_cmp (combinational load-use comparator); FSM, history and counters inline.
// TESTING
//  1. lw r3 (win0) then add r4,r3,r1 (win0) -> one cycle pc_write=0,idex_bubble=1; stall_cnt=1; add issues next.
//  2. Same pair, consumer in win1 -> no stall; dest=r0 -> no stall.
//  3. br_taken 1 cycle, FLUSH_CYCLES=2 -> ifid_flush=idex_bubble=1 for 2 cycles, flush_cnt=1.
//  4. Load-use hit with mem_wait=1 for 3 cycles -> all enables 0 for 3 cycles, then 1 bubble; stall_cnt=1.
//  5. br_taken during LD_STALL (LOAD_STALL=3) -> flush taken, stall abandoned; rst mid-FLUSH -> RUN next cycle.
//  6. CNT_W=4, 20 load-use stalls -> stall_cnt holds at 4'hF.

Source files
------------

// File: rtl/id_issue_ctrl_pkg.sv
// Shared constants, field widths and state encoding for the ID-stage issue/hazard controller.
// Pure declarations; no logic, no latency.
package id_issue_ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_W   = 3;
    localparam int WIN_W   = 2;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 16'h8040;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LD_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_FREEZE   = 2'd3;

    // What was last written into ID/EX; v=0 means a bubble sits in EX.
    typedef struct packed {
        logic             v;
        logic             memread;
        logic [REG_W-1:0] dest;
        logic [WIN_W-1:0] window;
    } ex_hist_t;

endpackage

// File: rtl/id_issue_ctrl_if.sv
// ID-stage decode fields and EX resolution in, pipeline write enables and statistics out.
// Master is the pipeline datapath, slave is the issue controller.
interface id_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    import id_issue_ctrl_pkg::*;

    logic [INSTR_W-1:0] id_instr;
    logic [WIN_W-1:0]   id_window;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic               id_use_rs;
    logic               id_use_rt;
    logic [REG_W-1:0]   id_dest;
    logic               id_regwrite;
    logic               id_memread;
    logic               br_taken;
    logic               mem_wait;

    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;
    logic               idex_bubble;
    logic               idex_en;
    logic [INSTR_W-1:0] idex_instr;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output id_instr, id_window, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dest, id_regwrite, id_memread, br_taken, mem_wait,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_en,
               idex_instr, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_instr, id_window, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dest, id_regwrite, id_memread, br_taken, mem_wait,
        output pc_write, ifid_write, ifid_flush, idex_bubble, idex_en,
               idex_instr, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/id_issue_ctrl_hazard_cmp.sv
// Load-use comparator: the EX-resident load writes a register the ID instruction reads (same window).
// Purely combinational.
module hazard_cmp
    import id_issue_ctrl_pkg::*;
(
    input  ex_hist_t         hist_i,
    input  logic [WIN_W-1:0] id_window_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    output logic             hit_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_use_rs_i && (id_rs_i == hist_i.dest);
    assign rt_match = id_use_rt_i && (id_rt_i == hist_i.dest);

    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign hit_o = hist_i.v && hist_i.memread && (hist_i.dest != '0) &&
                   (hist_i.window == id_window_i) && (rs_match || rt_match);

endmodule

// File: rtl/id_issue_ctrl.sv
// Decides per cycle whether ID issues into ID/EX or a bubble goes in; drives PC/IF-ID enables.
// Outputs combinational from state and inputs (zero latency); mem_wait freezes the whole pipe.
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR    = NOP_INSTR_DEF,
    parameter int                 LOAD_STALL   = 1,
    parameter int                 FLUSH_CYCLES = 1,
    parameter int                 CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst,
    id_issue_ctrl_if.slave      bus
);

    logic [1:0]       state_q, state_d, ret_q, ret_d, eff_state;
    logic [1:0]       cnt_q, cnt_d;
    ex_hist_t         hist_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             hit, stall_inc, flush_inc;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, idex_en;

    hazard_cmp u_hazard_cmp (
        .hist_i      (hist_q),
        .id_window_i (bus.id_window),
        .id_rs_i     (bus.id_rs),
        .id_rt_i     (bus.id_rt),
        .id_use_rs_i (bus.id_use_rs),
        .id_use_rt_i (bus.id_use_rt),
        .hit_o       (hit)
    );

    // While frozen, the saved state is what resumes once memory is ready.
    assign eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_en     = 1'b1;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = eff_state;
        ret_d       = ret_q;
        cnt_d       = cnt_q;

        if (rst) begin
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
        end else if (bus.mem_wait) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_en    = 1'b0;
            state_d    = ST_FREEZE;
            ret_d      = eff_state;
        end else if ((eff_state == ST_RUN || eff_state == ST_LD_STALL) && bus.br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            cnt_d       = 2'(FLUSH_CYCLES - 1);
        end else if (eff_state == ST_RUN && hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = (LOAD_STALL > 1) ? ST_LD_STALL : ST_RUN;
            cnt_d       = 2'(LOAD_STALL - 1);
        end else if (eff_state == ST_LD_STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            state_d     = (cnt_q == 2'd1) ? ST_RUN : ST_LD_STALL;
        end else if (eff_state == ST_FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_d       = cnt_q - 2'd1;
            state_d     = (cnt_q == 2'd1) ? ST_RUN : ST_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            cnt_q       <= '0;
            hist_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            if (idex_en) begin
                // A load that writes no register cannot feed a consumer.
                hist_q <= idex_bubble ? '0 :
                          ex_hist_t'{v:       1'b1,
                                     memread: bus.id_memread && bus.id_regwrite,
                                     dest:    bus.id_dest,
                                     window:  bus.id_window};
            end
            if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.idex_en     = idex_en;
    assign bus.idex_instr  = idex_bubble ? NOP_INSTR : bus.id_instr;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations, a negedge monitor compares.
module tb_id_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel;
    logic [15:0] id_instr;
    logic [1:0]  id_window;
    logic [2:0]  id_rs, id_rt, id_dest;
    logic        id_use_rs, id_use_rt, id_regwrite, id_memread, br_taken, mem_wait;

    id_issue_ctrl_if #(.CNT_W(4))  ifa ();
    id_issue_ctrl_if #(.CNT_W(16)) ifb ();

    assign ifa.id_instr = id_instr;       assign ifb.id_instr = id_instr;
    assign ifa.id_window = id_window;     assign ifb.id_window = id_window;
    assign ifa.id_rs = id_rs;             assign ifb.id_rs = id_rs;
    assign ifa.id_rt = id_rt;             assign ifb.id_rt = id_rt;
    assign ifa.id_use_rs = id_use_rs;     assign ifb.id_use_rs = id_use_rs;
    assign ifa.id_use_rt = id_use_rt;     assign ifb.id_use_rt = id_use_rt;
    assign ifa.id_dest = id_dest;         assign ifb.id_dest = id_dest;
    assign ifa.id_regwrite = id_regwrite; assign ifb.id_regwrite = id_regwrite;
    assign ifa.id_memread = id_memread;   assign ifb.id_memread = id_memread;
    assign ifa.br_taken = br_taken;       assign ifb.br_taken = br_taken;
    assign ifa.mem_wait = mem_wait;       assign ifb.mem_wait = mem_wait;

    id_issue_ctrl #(.LOAD_STALL(1), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
        .clk (clk), .rst (rst_a), .bus (ifa));
    id_issue_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut_b (
        .clk (clk), .rst (rst_b), .bus (ifb));

    // ctl bit order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_en}
    localparam logic [4:0] C_ISSUE = 5'b11001;
    localparam logic [4:0] C_STALL = 5'b00011;
    localparam logic [4:0] C_FLUSH = 5'b11111;
    localparam logic [4:0] C_FRZ   = 5'b00000;
    localparam logic [4:0] C_RST   = 5'b11011;

    typedef struct {
        logic        sel;
        logic [4:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [15:0] ins;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [4:0]  octl;
            logic [15:0] osc, ofc, oins;
            e = q.pop_front();
            if (e.sel) begin
                octl = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_bubble, ifb.idex_en};
                osc  = ifb.stall_cnt;
                ofc  = ifb.flush_cnt;
                oins = ifb.idex_instr;
            end else begin
                octl = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_bubble, ifa.idex_en};
                osc  = 16'(ifa.stall_cnt);
                ofc  = 16'(ifa.flush_cnt);
                oins = ifa.idex_instr;
            end
            n_chk++;
            if (octl !== e.ctl || osc !== e.sc || ofc !== e.fc || oins !== e.ins) begin
                n_fail++;
                $display("FAIL %s @%0t: got ctl=%b stall=%0d flush=%0d instr=%h, want ctl=%b stall=%0d flush=%0d instr=%h",
                         e.nm, $time, octl, osc, ofc, oins, e.ctl, e.sc, e.fc, e.ins);
            end
        end
    end

    task automatic cyc(input string nm, input logic [4:0] ctl, input int sc, input int fc);
        exp_t e;
        e.sel = sel; e.ctl = ctl; e.sc = 16'(sc); e.fc = 16'(fc); e.nm = nm;
        e.ins = ctl[1] ? 16'h8040 : id_instr;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic id_nop();
        id_instr = 16'h1234; id_window = 2'd0; id_rs = 3'd0; id_rt = 3'd0; id_dest = 3'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    endtask

    task automatic id_lw(input logic [2:0] d, input logic [1:0] w);
        id_instr = 16'h2000 | 16'(d); id_window = w; id_rs = 3'd0; id_rt = 3'd0; id_dest = d;
        id_use_rs = 1'b1; id_use_rt = 1'b0; id_regwrite = 1'b1; id_memread = 1'b1;
    endtask

    task automatic id_add(input logic [2:0] s, input logic [2:0] t, input logic [2:0] d,
                          input logic [1:0] w);
        id_instr = {7'h05, s, t, d}; id_window = w; id_rs = s; id_rt = t; id_dest = d;
        id_use_rs = 1'b1; id_use_rt = 1'b1; id_regwrite = 1'b1; id_memread = 1'b0;
    endtask

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0; br_taken = 1'b0; mem_wait = 1'b0;
        id_nop();
        @(posedge clk); #1;

        // ---- DUT A: LOAD_STALL=1, FLUSH_CYCLES=2, CNT_W=4 ----
        cyc("a_reset", C_RST, 0, 0);
        rst_a = 1'b0;
        id_lw(3'd3, 2'd0);           cyc("a_lw_issue",      C_ISSUE, 0, 0);
        id_add(3'd3, 3'd1, 3'd4, 0); cyc("a_loaduse_stall", C_STALL, 0, 0);
        cyc("a_add_issues", C_ISSUE, 1, 0);
        id_lw(3'd3, 2'd0);           cyc("a_lw2",           C_ISSUE, 1, 0);
        id_add(3'd3, 3'd1, 3'd4, 1); cyc("a_other_window",  C_ISSUE, 1, 0);
        id_lw(3'd0, 2'd0);           cyc("a_lw_r0",         C_ISSUE, 1, 0);
        id_add(3'd0, 3'd0, 3'd4, 0); cyc("a_r0_no_stall",   C_ISSUE, 1, 0);
        id_nop(); br_taken = 1'b1;   cyc("a_br_flush1",     C_FLUSH, 1, 0);
        br_taken = 1'b0;             cyc("a_br_flush2",     C_FLUSH, 1, 1);
        cyc("a_after_flush", C_ISSUE, 1, 1);
        id_lw(3'd5, 2'd0);           cyc("a_lw_r5",         C_ISSUE, 1, 1);
        id_add(3'd1, 3'd5, 3'd6, 0); mem_wait = 1'b1;
        cyc("a_freeze1", C_FRZ, 1, 1);
        cyc("a_freeze2", C_FRZ, 1, 1);
        cyc("a_freeze3", C_FRZ, 1, 1);
        mem_wait = 1'b0;             cyc("a_rt_stall_after_freeze", C_STALL, 1, 1);
        cyc("a_rt_issue", C_ISSUE, 2, 1);
        id_nop(); br_taken = 1'b1; mem_wait = 1'b1;
        cyc("a_freeze_beats_br", C_FRZ, 2, 1);
        mem_wait = 1'b0;             cyc("a_br_after_release", C_FLUSH, 2, 1);
        br_taken = 1'b0;             cyc("a_br_after_release2", C_FLUSH, 2, 2);
        cyc("a_issue_again", C_ISSUE, 2, 2);
        for (int i = 0; i < 20; i++) begin
            id_lw(3'd3, 2'd0);           cyc("a_sat_lw",    C_ISSUE, sat15(2 + i), 2);
            id_add(3'd3, 3'd1, 3'd4, 0); cyc("a_sat_stall", C_STALL, sat15(2 + i), 2);
        end
        id_nop();                    cyc("a_sat_hold", C_ISSUE, 15, 2);
        rst_a = 1'b1;

        // ---- DUT B: LOAD_STALL=3, FLUSH_CYCLES=2, CNT_W=16 ----
        sel = 1'b1;
        cyc("b_reset", C_RST, 0, 0);
        rst_b = 1'b0;
        id_lw(3'd3, 2'd0);           cyc("b_lw",       C_ISSUE, 0, 0);
        id_add(3'd3, 3'd1, 3'd4, 0); cyc("b_stall1",   C_STALL, 0, 0);
        cyc("b_stall2", C_STALL, 1, 0);
        br_taken = 1'b1;             cyc("b_br_abandons_stall", C_FLUSH, 2, 0);
        cyc("b_br_ignored_in_flush", C_FLUSH, 2, 1);
        id_nop(); br_taken = 1'b0;   cyc("b_issue",    C_ISSUE, 2, 1);
        br_taken = 1'b1;             cyc("b_br2",      C_FLUSH, 2, 1);
        br_taken = 1'b0; rst_b = 1'b1;
        cyc("b_rst_mid_flush", C_RST, 2, 2);
        rst_b = 1'b0;                cyc("b_run_after_rst", C_ISSUE, 0, 0);
        id_lw(3'd3, 2'd0);           cyc("b_lw2",      C_ISSUE, 0, 0);
        id_add(3'd3, 3'd1, 3'd4, 0); cyc("b_ls1",      C_STALL, 0, 0);
        cyc("b_ls2", C_STALL, 1, 0);
        cyc("b_ls3", C_STALL, 2, 0);
        cyc("b_ls_done", C_ISSUE, 3, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
